instr_fetch_unit: RTL

- Fetch-side initiator for the word-addressed instruction memory in the IF stage.
- Owns the fetch PC and drives address/read-enable into the memory, which returns data combinationally.
- Buffers fetched words with their PCs in a small prefetch FIFO and hands them to ID over a valid/ready handshake.
- Accepts redirects from EX (branch/jump), which flush the FIFO, and stops fetching at an all-zero word.

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 42 ++++
 rtl/instr_fetch_unit_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional build macro used by this slice: FETCH_PERF_EN (performance counters).
package if_pkg;

    localparam int INSTR_W  = 32;
    // Entry PC field is sized for the widest supported ADDR_W; unused upper bits are constant zero.
    localparam int PC_MAX_W = 64;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction memory port, ID handshake and EX redirect.
// master = fetch unit side, slave = memory/ID/EX side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import if_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_re;
    logic               imem_we;
    logic [INSTR_W-1:0] imem_din;
    logic [INSTR_W-1:0] imem_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    logic               halted;

    modport master (
        output imem_addr, imem_re, imem_we, imem_din,
        input  imem_rdata,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  redirect_valid, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_addr, imem_re, imem_we, imem_din,
        output imem_rdata,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output redirect_valid, redirect_pc,
        input  halted
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush overrides push and pop.
// Head reads as zero while empty.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok = push & ~flush & (~full | pop);
    assign pop_ok  = pop & ~flush & ~empty;

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage fetch initiator: owns the fetch PC, prefetches into a small FIFO, honours EX redirects
// and stops at an all-zero word. Define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      fifo_din;
    fetch_entry_t      fifo_head;

    logic              fetch_re;
    logic              stall;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_din.pc    = PC_MAX_W'(pc_q);
    assign fifo_din.instr = bus.imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect wins over everything: it voids the ID handshake and suppresses the memory read.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_re   = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        stall      = 1'b0;
        fifo_pop   = ~fifo_empty & bus.out_ready & ~bus.redirect_valid;

        if (bus.redirect_valid) begin
            fifo_flush = 1'b1;
            pc_d       = bus.redirect_pc;
            state_d    = FS_RUN;
        end else if (rst_n && state_q == FS_RUN) begin
            if ((fifo_count < CNT_W'(FIFO_DEPTH)) || fifo_pop) begin
                fetch_re = 1'b1;
                if (bus.imem_rdata != HALT_WORD) begin
                    fifo_push = 1'b1;
                    pc_d      = pc_q + ADDR_W'(1);
                end else begin
                    state_d = FS_HALT;
                end
            end else begin
                stall = fifo_full & ~fifo_pop;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.imem_re   = fetch_re;
    assign bus.imem_we   = 1'b0;
    assign bus.imem_din  = '0;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_instr = fifo_head.instr;
    assign bus.out_pc    = ADDR_W'(fifo_head.pc);
    assign bus.halted    = (state_q == FS_HALT);

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fifo_push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
